// File: rtl/rsa_modexp_ctrl_pkg.sv
// rsa_modexp_ctrl_pkg: shared width defaults and FSM encoding for the modexp sequencer
package rsa_modexp_ctrl_pkg;
  localparam int N_DEF = 512;
  localparam int EBITS_DEF = 512;
  typedef enum logic [2:0] {
    IDLE,
    SQ_START,
    SQ_WAIT,
    MUL_START,
    MUL_WAIT,
    POST_START,
    POST_WAIT
  } state_t;
endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// rsa_modexp_ctrl_if: host operand bus plus Montgomery multiplier handshake
interface rsa_modexp_ctrl_if
  import rsa_modexp_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int EBITS = EBITS_DEF,
  parameter int EW = $clog2(EBITS + 1)
);
  logic start;
  logic [N-1:0] in_x;
  logic [N-1:0] in_r;
  logic [N-1:0] in_m;
  logic [EBITS-1:0] in_e;
  logic [EW-1:0] in_e_len;
  logic busy;
  logic done;
  logic [N-1:0] result;
  logic mm_start;
  logic [N-1:0] mm_a;
  logic [N-1:0] mm_b;
  logic [N-1:0] mm_m;
  logic [N-1:0] mm_result;
  logic mm_done;
  modport slave (
    input start, in_x, in_r, in_m, in_e, in_e_len, mm_result, mm_done,
    output busy, done, result, mm_start, mm_a, mm_b, mm_m
  );
  modport master (
    output start, in_x, in_r, in_m, in_e, in_e_len, mm_result, mm_done,
    input busy, done, result, mm_start, mm_a, mm_b, mm_m
  );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right Montgomery square-and-multiply sequencer for X^E mod M
module rsa_modexp_ctrl
  import rsa_modexp_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int EBITS = EBITS_DEF,
  parameter int EW = $clog2(EBITS + 1)
) (
  input logic clk,
  input logic resetn,
  rsa_modexp_ctrl_if.slave bus
);
  localparam logic [N-1:0] MM_ONE = N'(1);
  state_t state_q;
  logic [N-1:0] x_q, a_q, result_q, mm_a_q, mm_b_q, mm_m_q;
  logic [EBITS-1:0] e_q;
  logic [EW-1:0] i_q, i_dec, len_clamped;
  logic busy_q, done_q, mm_start_q, e_bit, mm_ack;
  assign i_dec = i_q - EW'(1);
  assign e_bit = e_q[i_dec[$clog2(EBITS)-1:0]];
  assign len_clamped = (bus.in_e_len > EW'(EBITS)) ? EW'(EBITS) : bus.in_e_len;
  // a done coinciding with our own start pulse cannot belong to the new operation
  assign mm_ack = bus.mm_done & ~mm_start_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q <= '0;
      a_q <= '0;
      e_q <= '0;
      i_q <= '0;
      result_q <= '0;
      mm_a_q <= '0;
      mm_b_q <= '0;
      mm_m_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          x_q <= bus.in_x;
          e_q <= bus.in_e;
          a_q <= bus.in_r;
          mm_m_q <= bus.in_m;
          i_q <= len_clamped;
          busy_q <= 1'b1;
          state_q <= (len_clamped == '0) ? POST_START : SQ_START;
        end
        SQ_START: begin
          mm_a_q <= a_q;
          mm_b_q <= a_q;
          mm_start_q <= 1'b1;
          state_q <= SQ_WAIT;
        end
        SQ_WAIT: if (mm_ack) begin
          a_q <= bus.mm_result;
          i_q <= i_dec;
          state_q <= e_bit ? MUL_START : (i_dec == '0) ? POST_START : SQ_START;
        end
        MUL_START: begin
          mm_a_q <= a_q;
          mm_b_q <= x_q;
          mm_start_q <= 1'b1;
          state_q <= MUL_WAIT;
        end
        MUL_WAIT: if (mm_ack) begin
          a_q <= bus.mm_result;
          state_q <= (i_q == '0) ? POST_START : SQ_START;
        end
        POST_START: begin
          mm_a_q <= a_q;
          mm_b_q <= MM_ONE;
          mm_start_q <= 1'b1;
          state_q <= POST_WAIT;
        end
        POST_WAIT: if (mm_ack) begin
          result_q <= bus.mm_result;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.result = result_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_a = mm_a_q;
  assign bus.mm_b = mm_b_q;
  assign bus.mm_m = mm_m_q;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl: directed checks of the modexp sequencer against an exact Montgomery multiplier model
module tb_rsa_modexp_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  rsa_modexp_ctrl_if #(.N(8), .EBITS(8), .EW(4)) bus ();
  rsa_modexp_ctrl #(.N(8), .EBITS(8), .EW(4)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  int checks = 0;
  int failures = 0;
  int lat = 3;
  int cnt = 0;
  logic mdl_done = 1'b0;
  logic spur = 1'b0;
  logic [7:0] mdl_res = '0;
  logic [7:0] a_cap = '0;
  logic [7:0] b_cap = '0;
  int starts = 0, dones = 0, stab_err = 0, wide_err = 0, overlap_err = 0;
  logic done_prev = 1'b0;
  assign bus.mm_done = mdl_done | spur;
  assign bus.mm_result = mdl_res;

  // Mont(a,b) = a*b*R^-1 mod m with R = 2^8
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int rinv = 0;
    for (int r = 1; r < int'(m); r++) if ((256 * r) % int'(m) == 1) rinv = r;
    return 8'((int'(a) * int'(b) * rinv) % int'(m));
  endfunction

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (!resetn) cnt <= 0;
    else if (bus.mm_start) begin
      cnt <= lat;
      a_cap <= bus.mm_a;
      b_cap <= bus.mm_b;
    end else if (cnt == 1) begin
      cnt <= 0;
      mdl_done <= 1'b1;
      mdl_res <= mont(a_cap, b_cap, bus.mm_m);
    end else if (cnt > 1) cnt <= cnt - 1;
  end

  always @(negedge clk) begin
    if (bus.mm_start) starts <= starts + 1;
    if (bus.done) dones <= dones + 1;
    if (bus.done && done_prev) wide_err <= wide_err + 1;
    done_prev <= bus.done;
    if (cnt > 0 && (bus.mm_a !== a_cap || bus.mm_b !== b_cap)) stab_err <= stab_err + 1;
    if (bus.mm_start && bus.mm_done) overlap_err <= overlap_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] x, input logic [7:0] r, input logic [7:0] m,
                      input logic [7:0] e, input logic [3:0] len);
    bus.in_x = x;
    bus.in_r = r;
    bus.in_m = m;
    bus.in_e = e;
    bus.in_e_len = len;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    check(tag, 32'(seen), 1);
  endtask

  task automatic run(input string tag, input logic [7:0] x, input logic [7:0] r, input logic [7:0] m,
                     input logic [7:0] e, input logic [3:0] len, input int l,
                     output logic [7:0] res, output int nstarts, output int ndones);
    int s0, d0;
    lat = l;
    @(negedge clk);
    s0 = starts;
    d0 = dones;
    load(x, r, m, e, len);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(tag);
    res = bus.result;
    repeat (3) @(negedge clk);
    nstarts = starts - s0;
    ndones = dones - d0;
  endtask

  initial begin
    logic [7:0] res;
    int ns, nd, s0, d0;
    bus.start = 1'b0;
    load('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_mm_start", 32'(bus.mm_start), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_mm_a", 32'(bus.mm_a), 0);
    check("rst_mm_b", 32'(bus.mm_b), 0);
    check("rst_mm_m", 32'(bus.mm_m), 0);
    resetn = 1'b1;
    // 2^5 mod 13
    run("t1_done", 8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 3, res, ns, nd);
    check("t1_result", 32'(res), 6);
    check("t1_ops", 32'(ns), 6);
    check("t1_dones", 32'(nd), 1);
    check("t1_mm_m", 32'(bus.mm_m), 13);
    check("t1_busy_after", 32'(bus.busy), 0);
    // empty exponent: conversion only
    run("t2_done", 8'd5, 8'd9, 8'd13, 8'hFF, 4'd0, 3, res, ns, nd);
    check("t2_result", 32'(res), 1);
    check("t2_ops", 32'(ns), 1);
    check("t2_dones", 32'(nd), 1);
    // 3^15 mod 13
    run("t3_done", 8'd1, 8'd9, 8'd13, 8'h0F, 4'd4, 2, res, ns, nd);
    check("t3_result", 32'(res), 1);
    check("t3_ops", 32'(ns), 9);
    // length above EBITS clamps to 8: 8 squares + 2 multiplies + 1
    run("tc_done", 8'd5, 8'd9, 8'd13, 8'h05, 4'd15, 2, res, ns, nd);
    check("tc_result", 32'(res), 6);
    check("tc_ops", 32'(ns), 11);
    // held start plus spurious mm_done in IDLE and SQ_START
    lat = 3;
    @(negedge clk);
    s0 = starts;
    d0 = dones;
    load(8'd5, 8'd9, 8'd13, 8'd5, 4'd3);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    wait_done("t4_done");
    check("t4_result", 32'(bus.result), 6);
    repeat (5) @(negedge clk);
    check("t4_ops", 32'(starts - s0), 6);
    check("t4_dones", 32'(dones - d0), 1);
    check("t4_busy_after", 32'(bus.busy), 0);
    check("t4_result_hold", 32'(bus.result), 6);
    // abort during SQ_WAIT
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("t5_busy_pre", 32'(bus.busy), 1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_mm_start", 32'(bus.mm_start), 0);
    check("t5_result", 32'(bus.result), 0);
    repeat (4) @(negedge clk);
    run("t5_rerun_done", 8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 3, res, ns, nd);
    check("t5_rerun_result", 32'(res), 6);
    check("t5_rerun_ops", 32'(ns), 6);
    // latency extremes
    run("t6a_done", 8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 1, res, ns, nd);
    check("t6a_result", 32'(res), 6);
    check("t6a_ops", 32'(ns), 6);
    run("t6b_done", 8'd5, 8'd9, 8'd13, 8'd5, 4'd3, 1100, res, ns, nd);
    check("t6b_result", 32'(res), 6);
    check("t6b_dones", 32'(nd), 1);
    check("operand_stable", 32'(stab_err), 0);
    check("done_width", 32'(wide_err), 0);
    check("start_done_overlap", 32'(overlap_err), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
